// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AXI3 read channel (AR/R) between the
// instruction-fetch (IF) and data-memory (MEM) requesters.
// The channel carries one outstanding read at a time. MEM has priority over IF,
// but IF is forced to win after MAX_STARVE consecutive losses. IF responses
// that are still in flight when a pipeline flush arrives are discarded.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   if_req_* / mem_req_*     request handshake and virtual address
//   if_rsp_* / mem_rsp_*     read data, error flag, response handshake
//   if_flush                 drops the pending IF read
//   ar* / r*                 AXI3 read address and read data channels
module axi_read_arbiter #(
  parameter logic [3:0]  IF_ID      = 4'd0,
  parameter logic [3:0]  MEM_ID     = 4'd1,
  parameter int unsigned MAX_STARVE = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  output logic        if_rsp_err,
  input  logic        if_rsp_ready,
  input  logic        if_flush,
  input  logic        mem_req_valid,
  input  logic [31:0] mem_req_addr,
  output logic        mem_req_ready,
  output logic        mem_rsp_valid,
  output logic [31:0] mem_rsp_data,
  output logic        mem_rsp_err,
  input  logic        mem_rsp_ready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;

  state_e             state_q, state_d;
  logic               arvalid_q, arvalid_d;
  logic [31:0]        araddr_q, araddr_d;
  logic [3:0]         arid_q, arid_d;
  logic               owner_if_q, owner_if_d;
  logic               drop_q, drop_d;
  logic [CNT_W-1:0]   starve_q, starve_d;
  logic               if_elig;
  logic               grant_if;
  logic               grant_mem;

  // rid is not checked: a mismatching beat is consumed like any other.
  logic rid_unused;
  assign rid_unused = ^rid;

  // Single beat, 32-bit, INCR, normal access.
  assign arlen   = 4'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign arvalid = arvalid_q;
  assign araddr  = araddr_q;
  assign arid    = arid_q;

  // kseg0/kseg1 (0x8000_0000..0xBFFF_FFFF) fold onto physical 0x0000_0000.
  function automatic logic [31:0] xlate(input logic [31:0] va);
    if (va[31:29] == 3'b100 || va[31:29] == 3'b101) begin
      return {3'b000, va[28:0]};
    end
    return va;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      arvalid_q  <= 1'b0;
      araddr_q   <= 32'd0;
      arid_q     <= 4'd0;
      owner_if_q <= 1'b0;
      drop_q     <= 1'b0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      arvalid_q  <= arvalid_d;
      araddr_q   <= araddr_d;
      arid_q     <= arid_d;
      owner_if_q <= owner_if_d;
      drop_q     <= drop_d;
      starve_q   <= starve_d;
    end
  end

  // Grant, next-state and response routing
  always_comb begin
    state_d       = state_q;
    arvalid_d     = arvalid_q;
    araddr_d      = araddr_q;
    arid_d        = arid_q;
    owner_if_d    = owner_if_q;
    drop_d        = drop_q;
    starve_d      = starve_q;
    if_req_ready  = 1'b0;
    mem_req_ready = 1'b0;
    if_rsp_valid  = 1'b0;
    if_rsp_data   = 32'd0;
    if_rsp_err    = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'd0;
    mem_rsp_err   = 1'b0;
    rready        = 1'b0;
    if_elig       = if_req_valid && !if_flush;
    grant_if      = 1'b0;
    grant_mem     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        grant_if      = if_elig && (!mem_req_valid || starve_q == CNT_W'(MAX_STARVE));
        grant_mem     = mem_req_valid && !grant_if;
        if_req_ready  = grant_if;
        mem_req_ready = grant_mem;
        if (grant_if) begin
          araddr_d   = xlate(if_req_addr);
          arid_d     = IF_ID;
          owner_if_d = 1'b1;
          arvalid_d  = 1'b1;
          starve_d   = '0;
          state_d    = S_ADDR;
        end else if (grant_mem) begin
          araddr_d   = xlate(mem_req_addr);
          arid_d     = MEM_ID;
          owner_if_d = 1'b0;
          arvalid_d  = 1'b1;
          state_d    = S_ADDR;
          // IF lost a contested grant
          if (if_elig && starve_q != CNT_W'(MAX_STARVE)) begin
            starve_d = starve_q + CNT_W'(1);
          end
        end
      end
      S_ADDR: begin
        if (if_flush && owner_if_q) begin
          drop_d = 1'b1;
        end
        if (arready) begin
          arvalid_d = 1'b0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (if_flush && owner_if_q) begin
          drop_d = 1'b1;
        end
        if (!owner_if_q) begin
          mem_rsp_valid = rvalid;
          mem_rsp_data  = rdata;
          mem_rsp_err   = (rresp != 2'b00);
          rready        = mem_rsp_ready;
        end else if (drop_q) begin
          // Flushed IF read: sink the beat silently.
          rready = 1'b1;
        end else begin
          if_rsp_valid = rvalid;
          if_rsp_data  = rdata;
          if_rsp_err   = (rresp != 2'b00);
          rready       = if_rsp_ready;
        end
        // Last beat wins over a same-cycle flush so drop never leaks past IDLE.
        if (rvalid && rready && rlast) begin
          drop_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed self-checking bench for axi_read_arbiter.
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// before the following falling edge.
module tb_axi_read_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req_valid, if_rsp_ready, if_flush;
  logic [31:0] if_req_addr;
  logic        if_req_ready, if_rsp_valid, if_rsp_err;
  logic [31:0] if_rsp_data;
  logic        mem_req_valid, mem_rsp_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready, mem_rsp_valid, mem_rsp_err;
  logic [31:0] mem_rsp_data;
  logic [3:0]  arid, arlen, arcache;
  logic [31:0] araddr;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_read_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .if_rsp_ready(if_rsp_ready), .if_flush(if_flush),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .mem_rsp_ready(mem_rsp_ready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for arvalid (bounded) and complete the AR handshake.
  task automatic ar_phase();
    int n = 0;
    while (!arvalid && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (arvalid !== 1'b1) begin
      errors++;
      $display("FAIL ar_timeout: arvalid=%0b want 1", arvalid);
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
  endtask

  // Present one final beat and hold it until rready (bounded).
  task automatic beat(input logic [31:0] d, input logic [1:0] resp, input logic [3:0] id);
    int n = 0;
    rvalid = 1'b1; rdata = d; rresp = resp; rlast = 1'b1; rid = id;
    #1;
    while (!rready && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (rready !== 1'b1) begin
      errors++;
      $display("FAIL rready_timeout: rready=%0b want 1", rready);
    end
    step();
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    if_req_valid = 1'b0; if_req_addr = 32'd0; if_rsp_ready = 1'b0; if_flush = 1'b0;
    mem_req_valid = 1'b0; mem_req_addr = 32'd0; mem_rsp_ready = 1'b0;
    arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    step();
    step();
    checks++;
    if ({arvalid, araddr, arid, rready, if_req_ready, mem_req_ready,
         if_rsp_valid, mem_rsp_valid, if_rsp_err, mem_rsp_err} !== 45'd0) begin
      errors++;
      $display("FAIL reset_outputs: arvalid=%0b araddr=%h arid=%0d rready=%0b want all 0",
               arvalid, araddr, arid, rready);
    end
    checks++;
    if ({arlen, arsize, arburst, arlock, arcache, arprot} !==
        {4'd0, 3'b010, 2'b01, 2'd0, 4'd0, 3'd0}) begin
      errors++;
      $display("FAIL ar_constants: len=%0d size=%0d burst=%0d lock=%0d cache=%0d prot=%0d",
               arlen, arsize, arburst, arlock, arcache, arprot);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_mem();
    mem_req_valid = 1'b1; mem_req_addr = 32'hBFC0_0010;
    #1;
    checks++;
    if ({mem_req_ready, if_req_ready, arvalid} !== 3'b100) begin
      errors++;
      $display("FAIL mem_accept: mem_rdy=%0b if_rdy=%0b arvalid=%0b want 1 0 0",
               mem_req_ready, if_req_ready, arvalid);
    end
    step();
    mem_req_valid = 1'b0;
    checks++;
    if ({arvalid, arid, araddr} !== {1'b1, 4'd1, 32'h1FC0_0010}) begin
      errors++;
      $display("FAIL mem_ar: arvalid=%0b arid=%0d araddr=%h want 1 1 1fc00010", arvalid, arid, araddr);
    end
    step();
    step();
    arready = 1'b1;
    #1;
    checks++;
    if ({arvalid, araddr} !== {1'b1, 32'h1FC0_0010}) begin
      errors++;
      $display("FAIL ar_stable: arvalid=%0b araddr=%h want 1 1fc00010", arvalid, araddr);
    end
    step();
    arready = 1'b0;
    #1;
    checks++;
    if ({arvalid, rready, mem_rsp_valid} !== 3'b000) begin
      errors++;
      $display("FAIL ar_done: arvalid=%0b rready=%0b mem_rsp_valid=%0b want 0 0 0",
               arvalid, rready, mem_rsp_valid);
    end
    step();
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b00; rlast = 1'b1; rid = 4'd1;
    mem_rsp_ready = 1'b1;
    #1;
    checks++;
    if ({mem_rsp_valid, mem_rsp_data, mem_rsp_err, rready, if_rsp_valid} !==
        {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mem_beat: valid=%0b data=%h err=%0b rready=%0b if_valid=%0b want 1 deadbeef 0 1 0",
               mem_rsp_valid, mem_rsp_data, mem_rsp_err, rready, if_rsp_valid);
    end
    step();
    rvalid = 1'b0; rlast = 1'b0;
    mem_req_valid = 1'b1; mem_req_addr = 32'h0000_0300;
    #1;
    checks++;
    if ({mem_req_ready, arvalid} !== 2'b10) begin
      errors++;
      $display("FAIL mem_idle_after: mem_rdy=%0b arvalid=%0b want 1 0", mem_req_ready, arvalid);
    end
    step();
    mem_req_valid = 1'b0;
    ar_phase();
    beat(32'h0, 2'b00, 4'd1);
  endtask

  task automatic test_starvation();
    bit exp_if [8];
    exp_if = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    if_rsp_ready = 1'b1; mem_rsp_ready = 1'b1;
    if_req_addr = 32'h0040_0000; mem_req_addr = 32'hA000_0100;
    if_req_valid = 1'b1; mem_req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if ({if_req_ready, mem_req_ready} !== {exp_if[i], !exp_if[i]}) begin
        errors++;
        $display("FAIL starve_grant[%0d]: if_rdy=%0b mem_rdy=%0b want if=%0b", i,
                 if_req_ready, mem_req_ready, exp_if[i]);
      end
      step();
      checks++;
      if ({arid, araddr} !== (exp_if[i] ? {4'd0, 32'h0040_0000} : {4'd1, 32'h0000_0100})) begin
        errors++;
        $display("FAIL starve_ar[%0d]: arid=%0d araddr=%h want if=%0b", i, arid, araddr, exp_if[i]);
      end
      ar_phase();
      beat(32'h0, 2'b00, exp_if[i] ? 4'd0 : 4'd1);
    end
    if_req_valid = 1'b0; mem_req_valid = 1'b0;
  endtask

  task automatic test_flush();
    if_req_valid = 1'b1; if_req_addr = 32'h8000_0000; if_flush = 1'b1;
    #1;
    checks++;
    if (if_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_block: if_rdy=%0b want 0", if_req_ready);
    end
    if_flush = 1'b0;
    #1;
    checks++;
    if (if_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_if_accept: if_rdy=%0b want 1", if_req_ready);
    end
    step();
    if_req_valid = 1'b0;
    checks++;
    if ({arvalid, arid, araddr} !== {1'b1, 4'd0, 32'h0}) begin
      errors++;
      $display("FAIL flush_ar: arvalid=%0b arid=%0d araddr=%h want 1 0 00000000", arvalid, arid, araddr);
    end
    if_flush = 1'b1;
    step();
    if_flush = 1'b0;
    checks++;
    if (arvalid !== 1'b1) begin
      errors++;
      $display("FAIL flush_ar_hold: arvalid=%0b want 1", arvalid);
    end
    ar_phase();
    if_rsp_ready = 1'b0;
    rvalid = 1'b1; rdata = 32'h1234_5678; rlast = 1'b1; rid = 4'd0;
    #1;
    checks++;
    if ({rready, if_rsp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL flush_drop: rready=%0b if_rsp_valid=%0b want 1 0", rready, if_rsp_valid);
    end
    step();
    rvalid = 1'b0; rlast = 1'b0; if_rsp_ready = 1'b1;
    if_req_valid = 1'b1; if_req_addr = 32'h0000_1000;
    #1;
    checks++;
    if (if_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_reaccept: if_rdy=%0b want 1", if_req_ready);
    end
    step();
    if_req_valid = 1'b0;
    checks++;
    if (araddr !== 32'h0000_1000) begin
      errors++;
      $display("FAIL flush_reaccept_addr: araddr=%h want 00001000", araddr);
    end
    ar_phase();
    // Flush coinciding with the final beat: beat is still delivered.
    rvalid = 1'b1; rdata = 32'hCAFE_F00D; rlast = 1'b1; if_flush = 1'b1;
    #1;
    checks++;
    if ({if_rsp_valid, if_rsp_data, rready} !== {1'b1, 32'hCAFE_F00D, 1'b1}) begin
      errors++;
      $display("FAIL flush_last_beat: valid=%0b data=%h rready=%0b want 1 cafef00d 1",
               if_rsp_valid, if_rsp_data, rready);
    end
    step();
    rvalid = 1'b0; rlast = 1'b0; if_flush = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'h0000_2000;
    step();
    if_req_valid = 1'b0;
    ar_phase();
    rvalid = 1'b1; rdata = 32'h0BAD_CAFE; rlast = 1'b1;
    #1;
    checks++;
    if ({if_rsp_valid, if_rsp_data} !== {1'b1, 32'h0BAD_CAFE}) begin
      errors++;
      $display("FAIL drop_cleared: valid=%0b data=%h want 1 0badcafe", if_rsp_valid, if_rsp_data);
    end
    step();
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic test_backpressure();
    mem_req_valid = 1'b1; mem_req_addr = 32'h0000_0200;
    step();
    mem_req_valid = 1'b0;
    ar_phase();
    mem_rsp_ready = 1'b0;
    rvalid = 1'b1; rdata = 32'h55AA_55AA; rlast = 1'b1; rid = 4'd1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({rready, mem_rsp_valid, mem_rsp_data} !== {1'b0, 1'b1, 32'h55AA_55AA}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: rready=%0b valid=%0b data=%h want 0 1 55aa55aa", i,
                 rready, mem_rsp_valid, mem_rsp_data);
      end
      step();
    end
    mem_rsp_ready = 1'b1;
    #1;
    checks++;
    if (rready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: rready=%0b want 1", rready);
    end
    step();
    rvalid = 1'b0; rlast = 1'b0;
    mem_req_valid = 1'b1;
    #1;
    checks++;
    if (mem_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_idle: mem_rdy=%0b want 1", mem_req_ready);
    end
    step();
    mem_req_valid = 1'b0;
    ar_phase();
    beat(32'h0, 2'b00, 4'd1);
  endtask

  task automatic test_err();
    if_req_valid = 1'b1; if_req_addr = 32'h0000_0040;
    step();
    if_req_valid = 1'b0;
    ar_phase();
    rvalid = 1'b1; rdata = 32'hBAD0_BAD0; rresp = 2'b10; rlast = 1'b1; rid = 4'd0;
    #1;
    checks++;
    if ({if_rsp_valid, if_rsp_err, mem_rsp_valid} !== 3'b110) begin
      errors++;
      $display("FAIL err_flag: valid=%0b err=%0b mem_valid=%0b want 1 1 0",
               if_rsp_valid, if_rsp_err, mem_rsp_valid);
    end
    step();
    rvalid = 1'b0; rresp = 2'b00; rlast = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'h0000_0044;
    step();
    if_req_valid = 1'b0;
    ar_phase();
    rvalid = 1'b1; rdata = 32'h0000_0044; rlast = 1'b1;
    #1;
    checks++;
    if ({if_rsp_valid, if_rsp_err} !== 2'b10) begin
      errors++;
      $display("FAIL err_clear: valid=%0b err=%0b want 1 0", if_rsp_valid, if_rsp_err);
    end
    step();
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic test_rlast_rid();
    mem_req_valid = 1'b1; mem_req_addr = 32'h0000_0500;
    step();
    mem_req_valid = 1'b0;
    ar_phase();
    rvalid = 1'b1; rdata = 32'h1111_1111; rlast = 1'b0; rid = 4'd1;
    #1;
    checks++;
    if ({rready, mem_rsp_valid} !== 2'b11) begin
      errors++;
      $display("FAIL rlast0_beat: rready=%0b valid=%0b want 1 1", rready, mem_rsp_valid);
    end
    step();
    rdata = 32'h2222_2222; rlast = 1'b1; rid = 4'd7;
    #1;
    checks++;
    if ({mem_rsp_valid, mem_rsp_data} !== {1'b1, 32'h2222_2222}) begin
      errors++;
      $display("FAIL rlast0_stay: valid=%0b data=%h want 1 22222222", mem_rsp_valid, mem_rsp_data);
    end
    step();
    rvalid = 1'b0; rlast = 1'b0;
    mem_req_valid = 1'b1;
    #1;
    checks++;
    if (mem_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rid_mismatch_done: mem_rdy=%0b want 1", mem_req_ready);
    end
    step();
    mem_req_valid = 1'b0;
    ar_phase();
    beat(32'h0, 2'b00, 4'd1);
  endtask

  task automatic test_reset_mid();
    bit exp_if [4];
    exp_if = '{1'b0, 1'b0, 1'b0, 1'b1};
    if_req_addr = 32'h0000_0080; mem_req_addr = 32'h0000_0800;
    if_req_valid = 1'b1; mem_req_valid = 1'b1;
    step();
    if_req_valid = 1'b0; mem_req_valid = 1'b0;
    ar_phase();
    mem_rsp_ready = 1'b1; if_rsp_ready = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checks++;
    if ({arvalid, rready} !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset: arvalid=%0b rready=%0b want 0 0", arvalid, rready);
    end
    if_req_valid = 1'b1; mem_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({if_req_ready, mem_req_ready} !== {exp_if[i], !exp_if[i]}) begin
        errors++;
        $display("FAIL mid_reset_grant[%0d]: if_rdy=%0b mem_rdy=%0b want if=%0b", i,
                 if_req_ready, mem_req_ready, exp_if[i]);
      end
      step();
      ar_phase();
      beat(32'h0, 2'b00, exp_if[i] ? 4'd0 : 4'd1);
    end
    if_req_valid = 1'b0; mem_req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_mem();
    test_starvation();
    test_flush();
    test_backpressure();
    test_err();
    test_rlast_rid();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares the single AXI3 read channel (AR/R) between the instruction-fetch requester (IF) and the data-memory requester (MEM).
- Enforces one outstanding read at a time and fixed MEM-over-IF priority, with a starvation guard for IF.
- Discards in-flight IF responses after a pipeline flush.
- Sits between the IF/MEM stages and the top-level AXI master port.

Parameters:
- IF_ID, 4'd0, arid driven for IF reads.
- MEM_ID, 4'd1, arid driven for MEM reads.
- MAX_STARVE, 3, consecutive IF losses before IF is forced to win (legal 1..7).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- if_req_valid  in  1  IF read request
- if_req_addr  in  32  IF virtual address
- if_req_ready  out  1  IF request accepted this cycle
- if_rsp_valid  out  1  IF data valid
- if_rsp_data  out  32  IF read data
- if_rsp_err  out  1  rresp != OKAY for IF beat
- if_rsp_ready  in  1  IF can take data
- if_flush  in  1  pipeline flush; pending IF read must be discarded
- mem_req_valid  in  1  MEM read request
- mem_req_addr  in  32  MEM virtual address
- mem_req_ready  out  1  MEM request accepted
- mem_rsp_valid  out  1  MEM data valid
- mem_rsp_data  out  32  MEM read data
- mem_rsp_err  out  1  rresp != OKAY for MEM beat
- mem_rsp_ready  in  1  MEM can take data
- arid  out  4
- araddr  out  32
- arlen  out  4  constant 0
- arsize  out  3  constant 3'b010
- arburst  out  2  constant 2'b01
- arlock  out  2  constant 0
- arcache  out  4  constant 0
- arprot  out  3  constant 0
- arvalid  out  1
- arready  in  1
- rid  in  4
- rdata  in  32
- rresp  in  2
- rlast  in  1
- rvalid  in  1
- rready  out  1

Behaviour:
- Reset values: state IDLE, arvalid=0, araddr=0, arid=0, owner=MEM, drop=0, starve_cnt=0. All req_ready/rsp_valid/err outputs and rready are 0.
- States:
  - IDLE: no transaction.
  - ADDR: arvalid=1, waiting for arready.
  - DATA: waiting for the R beat.
- Grant (IDLE only, combinational):
  - IF is eligible when if_req_valid=1 and if_flush=0.
  - If only one requester is eligible, it wins.
  - If both are eligible, MEM wins unless starve_cnt==MAX_STARVE, in which case IF wins.
  - The winner's req_ready=1; the loser's req_ready=0.
- Accept: at the edge where req_valid&&req_ready, the block registers:
  - araddr, translated: addr[31:29] of 3'b100 or 3'b101 maps to {3'b000, addr[28:0]}; otherwise passed through.
  - arid = owner's ID, owner, and arvalid<=1.
  - State goes IDLE->ADDR.
  - arvalid is first high the cycle after acceptance.
- starve_cnt:
  - Increments (saturating at MAX_STARVE) when both are eligible and MEM is granted.
  - Clears when IF is granted.
  - Otherwise holds.
- ADDR: arvalid, araddr and arid stay stable until arready. On arvalid&&arready, arvalid<=0 and the state goes to DATA.
- DATA:
  - Owner not dropped: owner's rsp_valid=rvalid, rsp_data=rdata, rsp_err=(rresp!=0), rready=owner's rsp_ready. Non-owner rsp_valid=0.
  - Owner is IF with drop=1: rready=1 and if_rsp_valid=0.
  - On rvalid&&rready&&rlast, go to IDLE and clear drop.
  - If rid differs from the registered arid, the beat is still consumed; there is no error flag.
  - rlast=0 beats are consumed like any other beat and the state stays in DATA.
- Flush:
  - if_flush=1 while owner=IF in ADDR or DATA sets drop<=1. The AR handshake still completes.
  - In IDLE, flush only blocks the IF grant that cycle.
  - MEM transactions are unaffected.
  - A flush in the same cycle as the final IF beat: the beat is delivered if if_rsp_ready=1, and drop clears on return to IDLE.
- Throughput: at most one outstanding read. There is at least 1 IDLE cycle between the last R beat and the next arvalid.
- Reset mid-transaction returns all state to reset values. No AXI completion is awaited.

Test Plan:
- Single MEM read, if_req_valid=0:
  - mem_req_addr=0xBFC0_0010 accepted at cycle 0; arvalid=1, araddr=0x1FC0_0010, arid=1 at cycle 1.
  - arready at cycle 3; rvalid with rdata=0xDEADBEEF, rlast=1 at cycle 5 with mem_rsp_ready=1 gives mem_rsp_valid=1, data 0xDEADBEEF.
  - State IDLE at cycle 6.
- IF and MEM both request continuously, MAX_STARVE=3: grants are MEM, MEM, MEM, IF, MEM, MEM, MEM, IF; starve_cnt cycles 1,2,3,0.
- IF read at 0x8000_0000, then if_flush pulsed in ADDR: araddr=0x0000_0000, rready=1 on the beat, if_rsp_valid stays 0, and a new IF request is accepted afterwards.
- MEM response with mem_rsp_ready=0 for 4 cycles: rready=0, mem_rsp_valid=1 with data held by the slave, and the state stays in DATA until ready rises.
- rresp=2'b10 on an IF beat: if_rsp_err=1 with if_rsp_valid=1; the next transaction has err=0.
- reset=1 while in DATA: next cycle arvalid=0, rready=0, state IDLE, starve_cnt=0.
